pll_mdrp_responder: RTL and testbench

Responder end of the PLL dynamic-reconfiguration (MDRP) port: the block the PLL init initiator drives via mdopc/mdainc/mdwdi, returning mdrdo.
Holds a byte-addressed configuration register file, applies initiator writes, returns read data, and emulates PLL lock behaviour.
Used as the behavioural PLL stand-in for board-level simulation and as a soft config bank on boards without a hard MDRP.
Sits between the PLL init sequencer and the clock-generation logic.

---
 rtl/pll_mdrp_pkg.sv | 19 +
 rtl/pll_lock_timer.sv | 55 +++++
 rtl/pll_mdrp_responder.sv | 99 +++++++++
 tb/tb_pll_mdrp_responder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pll_mdrp_pkg.sv
// Shared MDRP definitions: opcode encoding, bus widths and lock-timer state type.
package pll_mdrp_pkg;

  localparam int MDRP_DATA_W = 8;
  localparam int MDRP_ADDR_W = 8;

  typedef enum logic [1:0] {
    MDOPC_NOP   = 2'b00,
    MDOPC_WRITE = 2'b01,
    MDOPC_READ  = 2'b10,
    MDOPC_ADDR  = 2'b11
  } mdrp_opc_t;

  typedef enum logic {
    LOCK_LOCKING = 1'b0,
    LOCK_LOCKED  = 1'b1
  } lock_state_t;

endpackage

// File: rtl/pll_lock_timer.sv
// Emulated PLL lock: counts LOCK_DELAY cycles after reset or the last restart, then locks.
module pll_lock_timer
  import pll_mdrp_pkg::*;
#(
  parameter int LOCK_DELAY = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_restart,
  output logic        o_lock,
  output lock_state_t o_state
);

  localparam int CW = $clog2(LOCK_DELAY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LOCK_DELAY);
  localparam logic [CW-1:0] ONE      = CW'(1);

  lock_state_t   r_state;
  lock_state_t   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= LOCK_LOCKING;
      r_cnt   <= LOAD_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A restart wins over the countdown, so lock drops the cycle after the write.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_restart) begin
      w_state_nxt = LOCK_LOCKING;
      w_cnt_nxt   = LOAD_VAL;
    end else begin
      case (r_state)
        LOCK_LOCKING: begin
          if (r_cnt == ONE) w_state_nxt = LOCK_LOCKED;
          else              w_cnt_nxt   = r_cnt - ONE;
        end
        LOCK_LOCKED: ;
        default: w_state_nxt = LOCK_LOCKING;
      endcase
    end
  end

  assign o_lock  = (r_state == LOCK_LOCKED);
  assign o_state = r_state;

endmodule

// File: rtl/pll_mdrp_responder.sv
// MDRP responder: byte-addressed config register file with address auto-increment,
// registered read data, sticky write-error flag and an emulated PLL lock.
module pll_mdrp_responder
  import pll_mdrp_pkg::*;
#(
  parameter int           DEPTH       = 64,
  parameter int           LOCK_DELAY  = 1000,
  parameter logic [511:0] RESET_IMAGE = 512'h0,
  parameter logic [63:0]  WRITE_MASK  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                   mdclk,
  input  logic                   reset,
  input  logic [1:0]             mdopc,
  input  logic                   mdainc,
  input  logic [MDRP_DATA_W-1:0] mdwdi,
  output logic [MDRP_DATA_W-1:0] mdrdo,
  output logic                   lock,
  input  logic [MDRP_ADDR_W-1:0] cfg_raddr,
  output logic [MDRP_DATA_W-1:0] cfg_rdata,
  output logic                   cfg_update,
  output logic                   wr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Registers beyond the 64 bytes carried by RESET_IMAGE reset to zero.
  localparam logic [8*256-1:0] IMG_FULL = {{(8*256-512){1'b0}}, RESET_IMAGE};

  logic [MDRP_DATA_W-1:0] r_regs [DEPTH];
  logic [MDRP_ADDR_W-1:0] r_addr;
  logic [MDRP_DATA_W-1:0] r_rdo;
  logic                   r_cfg_update;
  logic                   r_wr_err;

  mdrp_opc_t              w_opc;
  logic                   w_in_range;
  logic                   w_writable;
  logic                   w_wr_accept;
  logic                   w_wr_reject;
  logic [MDRP_DATA_W-1:0] w_rd_data;
  logic                   w_cfg_in_range;
  logic                   w_lock;
  lock_state_t            w_lock_state;

  // No back-pressure: every mdclk edge consumes exactly one opcode.
  assign w_opc       = mdrp_opc_t'(mdopc);
  assign w_in_range  = ({1'b0, r_addr} < 9'(DEPTH));
  assign w_writable  = (r_addr < 8'd64) ? WRITE_MASK[r_addr[5:0]] : 1'b1;
  assign w_wr_accept = (w_opc == MDOPC_WRITE) && w_in_range && w_writable;
  assign w_wr_reject = (w_opc == MDOPC_WRITE) && !(w_in_range && w_writable);
  assign w_rd_data   = w_in_range ? r_regs[r_addr[AW-1:0]] : 8'h00;

  assign w_cfg_in_range = ({1'b0, cfg_raddr} < 9'(DEPTH));
  assign cfg_rdata      = w_cfg_in_range ? r_regs[cfg_raddr[AW-1:0]] : 8'h00;

  always_ff @(posedge mdclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= IMG_FULL[8*i +: 8];
    end else if (w_wr_accept) begin
      r_regs[r_addr[AW-1:0]] <= mdwdi;
    end
  end

  always_ff @(posedge mdclk or posedge reset) begin
    if (reset) begin
      r_addr       <= '0;
      r_rdo        <= '0;
      r_cfg_update <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_cfg_update <= w_wr_accept;
      if (w_wr_reject) r_wr_err <= 1'b1;
      case (w_opc)
        MDOPC_ADDR:  r_addr <= mdwdi;
        MDOPC_WRITE: if (mdainc) r_addr <= r_addr + 8'd1;
        MDOPC_READ: begin
          r_rdo <= w_rd_data;
          if (mdainc) r_addr <= r_addr + 8'd1;
        end
        default: ;
      endcase
    end
  end

  pll_lock_timer #(
    .LOCK_DELAY(LOCK_DELAY)
  ) u_lock_timer (
    .i_clk    (mdclk),
    .i_rst    (reset),
    .i_restart(w_wr_accept),
    .o_lock   (w_lock),
    .o_state  (w_lock_state)
  );

  assign mdrdo      = r_rdo;
  assign cfg_update = r_cfg_update;
  assign wr_err     = r_wr_err;
  assign lock       = w_lock && (w_lock_state == LOCK_LOCKED);

endmodule

// File: tb/tb_pll_mdrp_responder.sv
// Directed bench for pll_mdrp_responder: reset, read/write, auto-increment, masking, wrap, async reset.
module tb_pll_mdrp_responder;

  localparam int           DEPTH      = 64;
  localparam int           LOCK_DELAY = 16;
  // bytes: 0=5A, 2=22, 5=55, all others 00
  localparam logic [511:0] IMG        = 512'h5500_0022_005A;
  localparam logic [63:0]  MASK       = 64'hFFFF_FFFF_FFFF_FFFB;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ADDR  = 2'b11;

  logic       mdclk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mdopc = OP_NOP;
  logic       mdainc = 1'b0;
  logic [7:0] mdwdi = 8'h00;
  logic [7:0] mdrdo;
  logic       lock;
  logic [7:0] cfg_raddr = 8'h00;
  logic [7:0] cfg_rdata;
  logic       cfg_update;
  logic       wr_err;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 mdclk = ~mdclk;

  pll_mdrp_responder #(
    .DEPTH(DEPTH), .LOCK_DELAY(LOCK_DELAY), .RESET_IMAGE(IMG), .WRITE_MASK(MASK)
  ) dut (
    .mdclk(mdclk), .reset(reset), .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi),
    .mdrdo(mdrdo), .lock(lock), .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata),
    .cfg_update(cfg_update), .wr_err(wr_err)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge mdclk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] opc, input logic [7:0] d, input logic inc);
    mdopc  = opc;
    mdwdi  = d;
    mdainc = inc;
    tick();
    mdopc  = OP_NOP;
    mdainc = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) tick();
    n_vec++; if (mdrdo !== 8'h00) begin n_err++; $display("FAIL rst_mdrdo got %h exp 00", mdrdo); end
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL rst_lock got %b exp 0", lock); end
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL rst_wr_err got %b exp 0", wr_err); end
    n_vec++; if (cfg_update !== 1'b0) begin n_err++; $display("FAIL rst_cfg_update got %b exp 0", cfg_update); end
    cfg_raddr = 8'h00; #1;
    n_vec++; if (cfg_rdata !== 8'h5A) begin n_err++; $display("FAIL rst_img0 got %h exp 5A", cfg_rdata); end
    reset = 1'b0;
    for (int k = 1; k <= LOCK_DELAY; k++) begin
      tick();
      n_vec++;
      if (lock !== (k >= LOCK_DELAY)) begin
        n_err++; $display("FAIL lock_rise cycle %0d got %b exp %b", k, lock, (k >= LOCK_DELAY));
      end
    end
    n_vec++; if (mdrdo !== 8'h00) begin n_err++; $display("FAIL idle_mdrdo got %h exp 00", mdrdo); end
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL idle_wr_err got %b exp 0", wr_err); end
  endtask

  task automatic test_write_read();
    int pulses;
    do_op(OP_ADDR, 8'h05, 1'b0);
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL wr_pre_lock got %b exp 1", lock); end
    do_op(OP_WRITE, 8'hA5, 1'b0);
    pulses = (cfg_update === 1'b1) ? 1 : 0;
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL wr_lock_drop got %b exp 0", lock); end
    cfg_raddr = 8'h05; #1;
    n_vec++; if (cfg_rdata !== 8'hA5) begin n_err++; $display("FAIL wr_cfg_rdata got %h exp A5", cfg_rdata); end
    do_op(OP_READ, 8'h00, 1'b0);
    if (cfg_update === 1'b1) pulses++;
    n_vec++; if (mdrdo !== 8'hA5) begin n_err++; $display("FAIL raw_mdrdo got %h exp A5", mdrdo); end
    for (int k = 2; k <= LOCK_DELAY; k++) begin
      tick();
      if (cfg_update === 1'b1) pulses++;
      n_vec++;
      if (lock !== (k == LOCK_DELAY)) begin
        n_err++; $display("FAIL relock cycle %0d got %b exp %b", k, lock, (k == LOCK_DELAY));
      end
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL cfg_update_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_write_mask();
    do_op(OP_ADDR, 8'h02, 1'b0);
    do_op(OP_WRITE, 8'h7E, 1'b0);
    n_vec++; if (cfg_update !== 1'b0) begin n_err++; $display("FAIL mask_cfg_update got %b exp 0", cfg_update); end
    n_vec++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL mask_wr_err got %b exp 1", wr_err); end
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL mask_lock got %b exp 1", lock); end
    tick();
    n_vec++; if (lock !== 1'b1) begin n_err++; $display("FAIL mask_lock_hold got %b exp 1", lock); end
    do_op(OP_READ, 8'h00, 1'b0);
    n_vec++; if (mdrdo !== 8'h22) begin n_err++; $display("FAIL mask_reg2 got %h exp 22", mdrdo); end
  endtask

  task automatic test_autoinc();
    do_op(OP_ADDR, 8'h3E, 1'b0);
    do_op(OP_WRITE, 8'h11, 1'b1);
    do_op(OP_WRITE, 8'h22, 1'b1);
    n_vec++; if (cfg_update !== 1'b1) begin n_err++; $display("FAIL inc_cfg_update got %b exp 1", cfg_update); end
    do_op(OP_WRITE, 8'h33, 1'b1);
    n_vec++; if (cfg_update !== 1'b0) begin n_err++; $display("FAIL inc_oob_update got %b exp 0", cfg_update); end
    n_vec++; if (wr_err !== 1'b1) begin n_err++; $display("FAIL inc_wr_err got %b exp 1", wr_err); end
    cfg_raddr = 8'h3E; #1;
    n_vec++; if (cfg_rdata !== 8'h11) begin n_err++; $display("FAIL inc_reg3E got %h exp 11", cfg_rdata); end
    cfg_raddr = 8'h3F; #1;
    n_vec++; if (cfg_rdata !== 8'h22) begin n_err++; $display("FAIL inc_reg3F got %h exp 22", cfg_rdata); end
    cfg_raddr = 8'h40; #1;
    n_vec++; if (cfg_rdata !== 8'h00) begin n_err++; $display("FAIL cfg_oob got %h exp 00", cfg_rdata); end
    do_op(OP_ADDR, 8'h3E, 1'b0);
    do_op(OP_READ, 8'h00, 1'b1);
    n_vec++; if (mdrdo !== 8'h11) begin n_err++; $display("FAIL rd_3E got %h exp 11", mdrdo); end
    do_op(OP_READ, 8'h00, 1'b1);
    n_vec++; if (mdrdo !== 8'h22) begin n_err++; $display("FAIL rd_3F got %h exp 22", mdrdo); end
    do_op(OP_READ, 8'h00, 1'b1);
    n_vec++; if (mdrdo !== 8'h00) begin n_err++; $display("FAIL rd_40 got %h exp 00", mdrdo); end
    tick();
    n_vec++; if (mdrdo !== 8'h00) begin n_err++; $display("FAIL nop_hold got %h exp 00", mdrdo); end
  endtask

  task automatic test_wrap();
    do_op(OP_ADDR, 8'h05, 1'b0);
    do_op(OP_READ, 8'h00, 1'b0);
    tick();
    n_vec++; if (mdrdo !== 8'hA5) begin n_err++; $display("FAIL nop_hold_a5 got %h exp A5", mdrdo); end
    do_op(OP_ADDR, 8'hFF, 1'b0);
    do_op(OP_READ, 8'h00, 1'b1);
    n_vec++; if (mdrdo !== 8'h00) begin n_err++; $display("FAIL wrap_rdFF got %h exp 00", mdrdo); end
    do_op(OP_READ, 8'h00, 1'b0);
    n_vec++; if (mdrdo !== 8'h5A) begin n_err++; $display("FAIL wrap_rd0 got %h exp 5A", mdrdo); end
  endtask

  task automatic test_async_reset();
    do_op(OP_ADDR, 8'h05, 1'b0);
    do_op(OP_WRITE, 8'hA5, 1'b0);
    do_op(OP_READ, 8'h00, 1'b0);
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL ar_locking got %b exp 0", lock); end
    #2 reset = 1'b1;
    #1;
    cfg_raddr = 8'h05; #0.5;
    n_vec++; if (mdrdo !== 8'h00) begin n_err++; $display("FAIL ar_mdrdo got %h exp 00", mdrdo); end
    n_vec++; if (lock !== 1'b0) begin n_err++; $display("FAIL ar_lock got %b exp 0", lock); end
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL ar_wr_err got %b exp 0", wr_err); end
    n_vec++; if (cfg_rdata !== 8'h55) begin n_err++; $display("FAIL ar_reg5 got %h exp 55", cfg_rdata); end
    cfg_raddr = 8'h3E; #0.5;
    n_vec++; if (cfg_rdata !== 8'h00) begin n_err++; $display("FAIL ar_reg3E got %h exp 00", cfg_rdata); end
    tick();
    reset = 1'b0;
    do_op(OP_READ, 8'h00, 1'b0);
    n_vec++; if (mdrdo !== 8'h5A) begin n_err++; $display("FAIL ar_addr0 got %h exp 5A", mdrdo); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_write_mask();
    test_autoinc();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
